// File: rtl/svm_ovo_seq.sv
// Time-multiplexed one-vs-one SVM: one signed MAC walks every class pair using an external
// registered coefficient ROM, accumulates votes, then picks the winner with a sequential argmax.
module svm_ovo_seq #(
    parameter int NUM_FEAT  = 4,
    parameter int FEAT_W    = 4,
    parameter int NUM_CLASS = 3,
    parameter int COEF_W    = 8,
    parameter int ACC_W     = 16,
    parameter int CLS_W     = $clog2(NUM_CLASS),
    localparam int NUM_PAIR = NUM_CLASS * (NUM_CLASS - 1) / 2,
    localparam int ADDR_W   = $clog2(NUM_PAIR * (NUM_FEAT + 1))
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_FEAT*FEAT_W-1:0]   inp,
    output logic [ADDR_W-1:0]            coef_addr,
    input  logic [ACC_W-1:0]             coef_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CLS_W-1:0]             out,
    output logic [NUM_CLASS*CLS_W-1:0]   predo
);

    localparam int K_W = $clog2(NUM_FEAT + 1);

    typedef enum logic [2:0] {IDLE, FETCH, MAC, VOTE, ARGMAX, DONE} state_t;

    state_t                      state_q, state_d;
    logic [NUM_FEAT*FEAT_W-1:0]  feat_q, feat_d;
    logic [ACC_W-1:0]            acc_q, acc_d;
    logic [K_W-1:0]              k_q, k_d;
    logic [ADDR_W-1:0]           base_q, base_d, addr_q, addr_d;
    logic [CLS_W-1:0]            pi_q, pi_d, pj_q, pj_d;
    logic [CLS_W-1:0]            c_q, c_d, best_q, best_d, bidx_q, bidx_d, out_q, out_d;
    logic [CLS_W-1:0]            votes_q [NUM_CLASS];
    logic [CLS_W-1:0]            votes_d [NUM_CLASS];
    logic [NUM_CLASS*CLS_W-1:0]  predo_q, predo_d, predo_pack;
    logic                        ovalid_q, ovalid_d;

    logic [FEAT_W-1:0]           feat_sel;
    logic signed [COEF_W-1:0]    w_raw;
    logic signed [ACC_W-1:0]     w_ext, f_ext, prod;
    logic [CLS_W-1:0]            cur_votes, win_cls;
    logic                        take, last_pair;

    always_comb begin
        feat_sel = '0;
        for (int unsigned f = 0; f < NUM_FEAT; f++)
            if (k_q == K_W'(f + 1)) feat_sel = feat_q[f*FEAT_W +: FEAT_W];
        w_raw = $signed(coef_data[COEF_W-1:0]);
        w_ext = ACC_W'(w_raw);
        f_ext = ACC_W'($signed({1'b0, feat_sel}));
        prod  = f_ext * w_ext;

        cur_votes  = '0;
        predo_pack = '0;
        for (int unsigned c = 0; c < NUM_CLASS; c++) begin
            if (c_q == CLS_W'(c)) cur_votes = votes_q[c];
            predo_pack[(NUM_CLASS-1-c)*CLS_W +: CLS_W] = votes_q[c];
        end
        take      = (c_q == '0) || (cur_votes > best_q);
        last_pair = (pi_q == CLS_W'(NUM_CLASS - 2)) && (pj_q == CLS_W'(NUM_CLASS - 1));
        win_cls   = acc_q[ACC_W-1] ? pj_q : pi_q;
    end

    always_comb begin
        state_d  = state_q;
        feat_d   = feat_q;
        acc_d    = acc_q;
        k_d      = k_q;
        base_d   = base_q;
        addr_d   = addr_q;
        pi_d     = pi_q;
        pj_d     = pj_q;
        c_d      = c_q;
        best_d   = best_q;
        bidx_d   = bidx_q;
        out_d    = out_q;
        predo_d  = predo_q;
        ovalid_d = ovalid_q;
        votes_d  = votes_q;

        case (state_q)
            IDLE: if (in_valid) begin
                feat_d  = inp;
                votes_d = '{default: '0};
                pi_d    = '0;
                pj_d    = CLS_W'(1);
                base_d  = '0;
                addr_d  = ADDR_W'(NUM_FEAT);
                state_d = FETCH;
            end
            FETCH: begin
                addr_d  = base_q;
                k_d     = '0;
                state_d = MAC;
            end
            MAC: begin
                acc_d = (k_q == '0) ? coef_data : acc_q + prod;
                if (k_q == K_W'(NUM_FEAT)) begin
                    state_d = VOTE;
                    addr_d  = last_pair ? '0 : base_q + ADDR_W'(2 * NUM_FEAT + 1);
                end else begin
                    k_d    = k_q + K_W'(1);
                    addr_d = base_q + ADDR_W'(k_q) + ADDR_W'(1);
                end
            end
            // VOTE already presents the next intercept address, so it doubles as that pair's fetch.
            VOTE: begin
                for (int unsigned c = 0; c < NUM_CLASS; c++)
                    if (win_cls == CLS_W'(c)) votes_d[c] = votes_q[c] + CLS_W'(1);
                if (last_pair) begin
                    c_d     = '0;
                    state_d = ARGMAX;
                end else begin
                    base_d  = base_q + ADDR_W'(NUM_FEAT + 1);
                    addr_d  = base_q + ADDR_W'(NUM_FEAT + 1);
                    k_d     = '0;
                    state_d = MAC;
                    if (pj_q == CLS_W'(NUM_CLASS - 1)) begin
                        pi_d = pi_q + CLS_W'(1);
                        pj_d = pi_q + CLS_W'(2);
                    end else begin
                        pj_d = pj_q + CLS_W'(1);
                    end
                end
            end
            ARGMAX: begin
                best_d = take ? cur_votes : best_q;
                bidx_d = take ? c_q : bidx_q;
                if (c_q == CLS_W'(NUM_CLASS - 1)) begin
                    out_d    = take ? c_q : bidx_q;
                    predo_d  = predo_pack;
                    ovalid_d = 1'b1;
                    state_d  = DONE;
                end else begin
                    c_d = c_q + CLS_W'(1);
                end
            end
            DONE: if (out_ready) begin
                ovalid_d = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            feat_q   <= '0;
            acc_q    <= '0;
            k_q      <= '0;
            base_q   <= '0;
            addr_q   <= '0;
            pi_q     <= '0;
            pj_q     <= '0;
            c_q      <= '0;
            best_q   <= '0;
            bidx_q   <= '0;
            out_q    <= '0;
            predo_q  <= '0;
            ovalid_q <= 1'b0;
            votes_q  <= '{default: '0};
        end else begin
            state_q  <= state_d;
            feat_q   <= feat_d;
            acc_q    <= acc_d;
            k_q      <= k_d;
            base_q   <= base_d;
            addr_q   <= addr_d;
            pi_q     <= pi_d;
            pj_q     <= pj_d;
            c_q      <= c_d;
            best_q   <= best_d;
            bidx_q   <= bidx_d;
            out_q    <= out_d;
            predo_q  <= predo_d;
            ovalid_q <= ovalid_d;
            votes_q  <= votes_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign coef_addr = addr_q;
    assign out_valid = ovalid_q;
    assign out       = out_q;
    assign predo     = predo_q;

endmodule
